// File: rtl/rx_backend_if.sv
`default_nettype none
// ============================================================================
//  Module   : rx_backend_if
//  Purpose  : Consumer-side valid/ready handshake of the UART receive FIFO.
//  Revision : 1.0  initial release
// ============================================================================
interface rx_backend_if;
  logic [7:0] rx_data_o;
  logic       rx_frame_err_o;
  logic       rx_parity_err_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_frame_err_o,
    output rx_parity_err_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_frame_err_o,
    input  rx_parity_err_o,
    input  rx_valid_o,
    output rx_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/rx_backend.sv
`default_nettype none
// ============================================================================
//  Module   : rx_backend
//  Purpose  : Checks raw 11-bit UART frames and queues byte + error flags in a
//             small FIFO drained through a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module rx_backend #(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_i,
  input  wire logic                     parity_en_i,
  input  wire logic                     parity_odd_i,
  input  wire logic                     stop_bits_i,
  input  wire logic [10:0]              frame_i,
  input  wire logic                     frame_valid_i,
  rx_backend_if.master                  rx,
  output logic      [$clog2(DEPTH):0]   rx_count_o,
  output logic                          overrun_o,
  input  wire logic                     overrun_clear_i,
  input  wire logic                     flush_i
);

  localparam int c_AW = $clog2(DEPTH);

  // Check stage
  logic [7:0] w_data;
  logic       w_stop_ok;
  logic       w_ferr;
  logic       w_perr;

  logic       r_stg_valid;
  logic [7:0] r_stg_data;
  logic       r_stg_ferr;
  logic       r_stg_perr;

  always_comb begin
    w_data    = frame_i[8:1];
    w_stop_ok = parity_en_i ? frame_i[10]
                            : (frame_i[9] & (frame_i[10] | ~stop_bits_i));
    w_ferr    = frame_i[0] | ~w_stop_ok;
    w_perr    = parity_en_i & ((^frame_i[9:1]) != parity_odd_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= 8'h00;
      r_stg_ferr  <= 1'b0;
      r_stg_perr  <= 1'b0;
    end else begin
      r_stg_valid <= frame_valid_i;
      if (frame_valid_i) begin
        r_stg_data <= w_data;
        r_stg_ferr <= w_ferr;
        r_stg_perr <= w_perr;
      end
    end
  end

  // FIFO: pointers carry one extra MSB so full and empty are distinguishable
  logic [9:0]      r_mem [DEPTH];
  logic [c_AW:0]   r_wr;
  logic [c_AW:0]   r_rd;
  logic [c_AW:0]   w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [9:0]      w_head;

  always_comb begin
    w_count = r_wr - r_rd;
    w_empty = (r_wr == r_rd);
    w_full  = (r_wr[c_AW] != r_rd[c_AW]) &&
              (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    w_pop   = ~w_empty & rx.rx_ready_i;
    w_push  = r_stg_valid & (~w_full | w_pop);
    w_drop  = r_stg_valid & w_full & ~w_pop & ~flush_i;
    w_head  = r_mem[r_rd[c_AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i && !rst_i)
      r_mem[r_wr[c_AW-1:0]] <= {r_stg_ferr, r_stg_perr, r_stg_data};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (c_AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (c_AW+1)'(1);
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_i) begin
    if (rst_i)
      overrun_o <= 1'b0;
    else if (w_drop)
      overrun_o <= 1'b1;
    else if (overrun_clear_i)
      overrun_o <= 1'b0;
  end

  always_comb begin
    rx_count_o         = w_count;
    rx.rx_valid_o      = ~w_empty;
    rx.rx_data_o       = w_empty ? 8'h00 : w_head[7:0];
    rx.rx_parity_err_o = ~w_empty & w_head[8];
    rx.rx_frame_err_o  = ~w_empty & w_head[9];
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_backend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_backend
//  Purpose  : Directed self-checking bench for rx_backend.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_backend;

  logic        clk = 1'b0;
  logic        rst;
  logic        parity_en;
  logic        parity_odd;
  logic        stop_bits;
  logic [10:0] frame;
  logic        frame_valid;
  logic [2:0]  count;
  logic        overrun;
  logic        overrun_clear;
  logic        flush;

  int n_chk = 0;
  int n_err = 0;

  rx_backend_if u_if ();

  rx_backend #(.DEPTH(4)) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .parity_en_i     (parity_en),
    .parity_odd_i    (parity_odd),
    .stop_bits_i     (stop_bits),
    .frame_i         (frame),
    .frame_valid_i   (frame_valid),
    .rx              (u_if),
    .rx_count_o      (count),
    .overrun_o       (overrun),
    .overrun_clear_i (overrun_clear),
    .flush_i         (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {bit10, bit9, data, start}
  function automatic logic [10:0] mk(input logic b10, input logic b9, input logic [7:0] d);
    return {b10, b9, d, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f);
    frame       = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {31'd0, u_if.rx_valid_o}, 32'd1);
    chk(tag, {24'd0, u_if.rx_data_o}, {24'd0, exp});
    u_if.rx_ready_i = 1'b1;
    tick();
    u_if.rx_ready_i = 1'b0;
  endtask

  task automatic head_chk(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    chk({tag, "_valid"}, {31'd0, u_if.rx_valid_o}, 32'd1);
    chk({tag, "_data"},  {24'd0, u_if.rx_data_o}, {24'd0, d});
    chk({tag, "_ferr"},  {31'd0, u_if.rx_frame_err_o}, {31'd0, fe});
    chk({tag, "_perr"},  {31'd0, u_if.rx_parity_err_o}, {31'd0, pe});
  endtask

  initial begin
    rst = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; stop_bits = 1'b0;
    frame = '0; frame_valid = 1'b0; overrun_clear = 1'b0; flush = 1'b0;
    u_if.rx_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", {31'd0, u_if.rx_valid_o}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_data",  {24'd0, u_if.rx_data_o}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun}, 32'd0);

    // Basic frame, 2-cycle latency
    send(mk(1'b1, 1'b1, 8'hAA));
    chk("lat_n1_valid", {31'd0, u_if.rx_valid_o}, 32'd0);
    tick();
    head_chk("t1", 8'hAA, 1'b0, 1'b0);
    chk("t1_count", {29'd0, count}, 32'd1);
    pop_chk("t1_pop", 8'hAA);
    chk("t1_empty", {29'd0, count}, 32'd0);

    // Ready on empty FIFO does nothing
    u_if.rx_ready_i = 1'b1;
    tick();
    u_if.rx_ready_i = 1'b0;
    chk("empty_ready_count", {29'd0, count}, 32'd0);

    // Odd parity on 0x01: one data bit set, so P=0 is already odd
    parity_en = 1'b1; parity_odd = 1'b1;
    send(mk(1'b1, 1'b0, 8'h01)); tick();
    head_chk("par_p0", 8'h01, 1'b0, 1'b0);
    pop_chk("par_p0_pop", 8'h01);
    send(mk(1'b1, 1'b1, 8'h01)); tick();
    head_chk("par_p1", 8'h01, 1'b0, 1'b1);
    pop_chk("par_p1_pop", 8'h01);
    send(mk(1'b0, 1'b0, 8'h01)); tick();
    head_chk("par_stop0", 8'h01, 1'b1, 1'b0);
    pop_chk("par_stop0_pop", 8'h01);
    // Even parity, 0x03 with P=0 is correct; bad start bit
    parity_odd = 1'b0;
    send(mk(1'b1, 1'b0, 8'h03) | 11'h001); tick();
    head_chk("even_start1", 8'h03, 1'b1, 1'b0);
    pop_chk("even_start1_pop", 8'h03);

    // Two stop bits without parity
    parity_en = 1'b0; stop_bits = 1'b1;
    send(mk(1'b0, 1'b1, 8'h3C)); tick();
    head_chk("stop2_bad", 8'h3C, 1'b1, 1'b0);
    pop_chk("stop2_bad_pop", 8'h3C);
    stop_bits = 1'b0;
    send(mk(1'b0, 1'b1, 8'h3C)); tick();
    head_chk("stop1_ok", 8'h3C, 1'b0, 1'b0);
    pop_chk("stop1_ok_pop", 8'h3C);

    // Five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send(mk(1'b1, 1'b1, 8'(i * 8'h11)));
    tick();
    chk("ovf_count", {29'd0, count}, 32'd4);
    chk("ovf_flag",  {31'd0, overrun}, 32'd1);
    pop_chk("ovf_pop1", 8'h11);
    pop_chk("ovf_pop2", 8'h22);
    pop_chk("ovf_pop3", 8'h33);
    pop_chk("ovf_pop4", 8'h44);
    chk("ovf_drained", {31'd0, u_if.rx_valid_o}, 32'd0);
    chk("ovf_sticky", {31'd0, overrun}, 32'd1);
    overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;
    chk("ovf_cleared", {31'd0, overrun}, 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) send(mk(1'b1, 1'b1, 8'hA0 + 8'(i)));
    tick();
    chk("full_count", {29'd0, count}, 32'd4);
    send(mk(1'b1, 1'b1, 8'hA5));
    u_if.rx_ready_i = 1'b1; tick(); u_if.rx_ready_i = 1'b0;
    chk("pp_count", {29'd0, count}, 32'd4);
    chk("pp_no_ovf", {31'd0, overrun}, 32'd0);
    pop_chk("pp_pop1", 8'hA2);
    pop_chk("pp_pop2", 8'hA3);
    pop_chk("pp_pop3", 8'hA4);
    pop_chk("pp_pop4", 8'hA5);

    // Flush with a concurrent frame
    send(mk(1'b1, 1'b1, 8'hB1));
    send(mk(1'b1, 1'b1, 8'hB2));
    tick();
    chk("pre_flush_count", {29'd0, count}, 32'd2);
    frame = mk(1'b1, 1'b1, 8'hB3); frame_valid = 1'b1; flush = 1'b1;
    tick();
    frame_valid = 1'b0; flush = 1'b0;
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_valid", {31'd0, u_if.rx_valid_o}, 32'd0);
    tick(); tick();
    chk("flush_dropped", {29'd0, count}, 32'd0);

    // Reset mid-operation
    send(mk(1'b1, 1'b1, 8'hC1));
    send(mk(1'b1, 1'b1, 8'hC2));
    tick();
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    send(mk(1'b1, 1'b1, 8'hC3));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_count", {29'd0, count}, 32'd0);
    chk("mrst_valid", {31'd0, u_if.rx_valid_o}, 32'd0);
    chk("mrst_data",  {24'd0, u_if.rx_data_o}, 32'd0);
    chk("mrst_ovr",   {31'd0, overrun}, 32'd0);
    tick();
    chk("mrst_lost", {29'd0, count}, 32'd0);
    send(mk(1'b1, 1'b1, 8'h5A));
    chk("post_rst_n1", {31'd0, u_if.rx_valid_o}, 32'd0);
    tick();
    head_chk("post_rst", 8'h5A, 1'b0, 1'b0);
    chk("post_rst_count", {29'd0, count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
